// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency instruction memory
// and delivers {instr, pc, pc+4, valid} to decode through the IF/ID register.
module inst_fetch #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr_r,
  input  logic [31:0]       imem_data_out,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic              id_valid,
  output logic              misalign
);

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_m_q, pc_m_d;
  logic            vld_m_q, vld_m_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [PC_W-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic            id_valid_q, id_valid_d;
  logic            misalign_q, misalign_d;

  // On a held cycle re-read the word already in the memory output register.
  assign imem_addr_r = (stall && !redirect_valid) ? pc_m_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];

  // Next-state: redirect > stall > advance.
  always_comb begin
    pc_d          = pc_q;
    pc_m_d        = pc_m_q;
    vld_m_d       = vld_m_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    misalign_d    = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_target[31:2], 2'b00};
      pc_m_d     = pc_q;
      vld_m_d    = 1'b0;
      id_valid_d = 1'b0;
      misalign_d = |redirect_target[1:0];
    end else if (!stall) begin
      id_instr_d    = imem_data_out;
      id_pc_d       = pc_m_q;
      id_pc_plus4_d = pc_m_q + PC_STEP;
      id_valid_d    = vld_m_q;
      pc_m_d        = pc_q;
      vld_m_d       = 1'b1;
      pc_d          = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q          <= RESET_PC;
      pc_m_q        <= '0;
      vld_m_q       <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= PC_STEP;
      id_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pc_m_q        <= pc_m_d;
      vld_m_q       <= vld_m_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random stall/redirect traffic, checked
// against a stream-level model of which PC decode should see next.
module tb_inst_fetch;

  localparam int unsigned ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_target = '0;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_data_out = '0;
  logic [31:0]       id_instr, id_pc, id_pc_plus4;
  logic              id_valid, misalign;

  logic [31:0] mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the stream of PCs decode should receive, plus the visible IF/ID contents.
  logic [31:0] exp_next;
  int          bubbles;
  logic        e_valid, e_known, e_mis;
  logic [31:0] e_pc, e_p4, e_instr;

  inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr_r(imem_addr_r),
    .imem_data_out(imem_data_out), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory with a registered read port.
  always @(posedge clk) imem_data_out <= mem[imem_addr_r];

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [ADDR_W-1:0] idx;
    idx = pc[ADDR_W+1:2];
    return mem[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_next = RESET_PC;
    bubbles  = 1;
    e_valid  = 1'b0;
    e_known  = 1'b1;
    e_mis    = 1'b0;
    e_pc     = 32'h0;
    e_p4     = 32'h4;
    e_instr  = 32'h0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] t);
    e_mis = 1'b0;
    if (rv) begin
      e_valid  = 1'b0;
      e_mis    = (t[1:0] != 2'b00);
      exp_next = {t[31:2], 2'b00};
      bubbles  = 1;
    end else if (!s) begin
      if (bubbles > 0) begin
        bubbles = 0;
        e_valid = 1'b0;
        e_known = 1'b0;
      end else begin
        e_valid  = 1'b1;
        e_known  = 1'b1;
        e_pc     = exp_next;
        e_p4     = exp_next + 32'd4;
        e_instr  = word_at(exp_next);
        exp_next = exp_next + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    check("id_valid", 32'(id_valid), 32'(e_valid));
    check("misalign", 32'(misalign), 32'(e_mis));
    if (e_known) begin
      check("id_pc", id_pc, e_pc);
      check("id_pc_plus4", id_pc_plus4, e_p4);
      check("id_instr", id_instr, e_instr);
    end
  endtask

  // One cycle: drive at negedge, check the fetch address, clock, check IF/ID.
  task automatic step(input logic s, input logic rv, input logic [31:0] t);
    logic [31:0] fpc;
    stall = s;
    redirect_valid = rv;
    redirect_target = t;
    #1;
    if (s && !rv) begin
      if (bubbles == 0) check("imem_addr_stall", 32'(imem_addr_r), 32'(exp_next[ADDR_W+1:2]));
    end else begin
      fpc = (bubbles == 0) ? exp_next + 32'd4 : exp_next;
      check("imem_addr", 32'(imem_addr_r), 32'(fpc[ADDR_W+1:2]));
    end
    @(posedge clk);
    model_edge(s, rv, t);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h1000_0000 + 32'(i);
    model_reset();
    @(negedge clk);
    check_outputs();
    check("reset_addr", 32'(imem_addr_r), 32'(RESET_PC[ADDR_W+1:2]));
    clr = 1'b0;

    // 1: startup latency and steady stream
    step(1'b0, 1'b0, 32'h0);
    check("first_edge_invalid", 32'(id_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("first_valid_pc", id_pc, 32'h0);
    check("first_valid_instr", id_instr, 32'h1000_0000);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("third_pc", id_pc, 32'h8);

    // 2: stall while id_pc=8
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("stall_frozen_pc", id_pc, 32'h8);
    check("stall_addr", 32'(imem_addr_r), 32'h3);
    step(1'b0, 1'b0, 32'h0);
    check("post_stall_pc", id_pc, 32'hC);
    check("post_stall_instr", id_instr, 32'h1000_0003);
    step(1'b0, 1'b0, 32'h0);

    // 3: redirect to 0x100
    step(1'b0, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("redir_pc", id_pc, 32'h100);
    check("redir_instr", id_instr, 32'h1000_0040);

    // 4: redirect beats stall
    step(1'b1, 1'b1, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("redir_stall_pc", id_pc, 32'h20);

    // 5: memory-index wrap, then a misaligned target
    step(1'b0, 1'b1, 32'h0000_0FFC);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h102);
    check("misalign_pulse", 32'(misalign), 32'h1);
    step(1'b0, 1'b0, 32'h0);
    check("misalign_clears", 32'(misalign), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("misalign_fetch_pc", id_pc, 32'h100);

    // 32-bit PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);

    // 6: asynchronous clear between edges
    stall = 1'b0;
    redirect_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    model_reset();
    check("async_clr_valid", 32'(id_valid), 32'h0);
    check("async_clr_pc", id_pc, 32'h0);
    check("async_clr_p4", id_pc_plus4, 32'h4);
    check("async_clr_addr", 32'(imem_addr_r), 32'(RESET_PC[ADDR_W+1:2]));
    @(negedge clk);
    clr = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("refetch_pc", id_pc, RESET_PC);

    // Random stall/redirect traffic
    for (int n = 0; n < 400; n++) begin
      logic s, rv;
      logic [31:0] t;
      rv = ($urandom_range(0, 99) < 12);
      s  = ($urandom_range(0, 3) == 0);
      t  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8191));
      step(s, rv, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
